// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and load/store.
// Data beats fetch, bounded by a burst limit; an ack timeout keeps a dead memory from hanging the core.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_DATA_BURST = 2,
  parameter int TIMEOUT        = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              err_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int BW = $clog2(MAX_DATA_BURST + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DATA_BURST);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  state_t          state;
  state_t          state_next;
  logic            owner_data;
  logic [BW-1:0]   burst_cnt;
  logic [TW-1:0]   to_cnt;
  logic            busy;
  logic            grant_data;
  logic            grant_fetch;
  logic            timeout_hit;

  // A waiting fetch only loses to data while the burst budget is not used up.
  assign grant_data  = d_req & (~if_req | (burst_cnt < BURST_MAX));
  assign grant_fetch = ~grant_data & if_req;
  assign busy        = (state == FETCH) || (state == DATA);
  assign timeout_hit = busy & ~mem_ack & (to_cnt == TO_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_data) begin
          state_next = DATA;
        end else if (grant_fetch) begin
          state_next = FETCH;
        end
      end
      FETCH, DATA: begin
        if (mem_ack || timeout_hit) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req  = 1'b0;
    if_ready = 1'b0;
    d_ready  = 1'b0;
    case (state)
      FETCH, DATA: mem_req = 1'b1;
      DONE: begin
        if_ready = ~owner_data;
        d_ready  = owner_data;
      end
      default: ;
    endcase
  end

  assign stall = (if_req & ~if_ready) | (d_req & ~d_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_data  <= 1'b0;
      burst_cnt   <= '0;
      to_cnt      <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      if_rdata    <= '0;
      d_rdata     <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (grant_data) begin
            owner_data <= 1'b1;
            mem_we     <= d_we;
            mem_addr   <= d_addr;
            mem_wdata  <= d_wdata;
            if (!if_req) begin
              burst_cnt <= '0;
            end else if (burst_cnt != BURST_MAX) begin
              burst_cnt <= burst_cnt + BW'(1);
            end
          end else if (grant_fetch) begin
            owner_data <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            burst_cnt  <= '0;
          end
        end
        FETCH, DATA: begin
          if (mem_ack) begin
            if (state == FETCH) begin
              if_rdata <= mem_rdata;
            end else if (!mem_we) begin
              d_rdata <= mem_rdata;
            end
          end else if (to_cnt == TO_LAST) begin
            // Abort: the requester sees a zero word and the sticky flag.
            err_timeout <= 1'b1;
            if (state == FETCH) begin
              if_rdata <= '0;
            end else begin
              d_rdata <= '0;
            end
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  a_to_cnt_bound : assert property (@(posedge clk) disable iff (rst)
    busy |-> (to_cnt <= TO_LAST));
  a_burst_bound : assert property (@(posedge clk) disable iff (rst)
    burst_cnt <= BURST_MAX);
  a_ready_exclusive : assert property (@(posedge clk) disable iff (rst)
    !(if_ready && d_ready));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: memory model with programmable latency,
// scoreboard queues of expected read data per requester, grant/mem_req-length monitor.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        stall;
  logic        err_timeout;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_DATA_BURST(2), .TIMEOUT(15)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pattern(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C22_0004;
    return {~a[15:0], a[15:0]};
  endfunction

  // Memory model: ack after mem_lat waiting cycles, or never when mem_dead.
  logic [31:0] mem [logic [31:0]];
  int mem_lat  = 0;
  bit mem_dead = 1'b0;
  int wait_cnt = 0;

  always @(negedge clk) begin
    if (mem_req && !mem_dead && !mem_ack && wait_cnt == mem_lat) begin
      mem_ack = 1'b1;
      if (mem_we) mem[mem_addr] = mem_wdata;
      else mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : pattern(mem_addr);
    end else begin
      mem_ack  = 1'b0;
      wait_cnt = mem_req ? wait_cnt + 1 : 0;
    end
  end

  // Monitor: grant log at each mem_req rise, mem_req high-time log, d_ready pulse count.
  logic        req_q = 1'b0;
  int          req_len = 0;
  int          d_ready_cnt = 0;
  logic [31:0] g_addr[$];
  logic        g_we[$];
  logic [31:0] g_wdata[$];
  int          len_log[$];

  always @(negedge clk) begin
    if (mem_req && !req_q) begin
      g_addr.push_back(mem_addr);
      g_we.push_back(mem_we);
      g_wdata.push_back(mem_wdata);
    end
    if (mem_req) req_len++;
    else if (req_q) begin
      len_log.push_back(req_len);
      req_len = 0;
    end
    if (d_ready) d_ready_cnt++;
    req_q = mem_req;
  end

  // Scoreboard: expected rdata per requester, pushed at drive time.
  logic [31:0] exp_if[$];
  logic [31:0] exp_d[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] last_d = '0;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : pattern(a);
  endfunction

  task automatic wait_done(input bit is_data, input string tag, output int cycles);
    logic [31:0] exp;
    bit seen;
    seen   = 1'b0;
    cycles = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cycles++;
      if (is_data ? d_ready : if_ready) begin
        seen = 1'b1;
        break;
      end
    end
    exp = is_data ? exp_d.pop_front() : exp_if.pop_front();
    if (!seen) check({tag, "_ready_seen"}, 64'd0, 64'd1);
    else check(tag, is_data ? d_rdata : if_rdata, exp);
  endtask

  task automatic fetch_op(input logic [31:0] a, input bit dead, input string tag);
    int c;
    if_addr = a;
    if_req  = 1'b1;
    exp_if.push_back(dead ? 32'h0 : ref_read(a));
    wait_done(1'b0, tag, c);
  endtask

  task automatic data_op(input bit we, input logic [31:0] a, input logic [31:0] wd,
                         input string tag);
    int c;
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    d_req   = 1'b1;
    if (we) begin
      exp_d.push_back(last_d);
      ref_mem[a] = wd;
    end else begin
      last_d = ref_read(a);
      exp_d.push_back(last_d);
    end
    wait_done(1'b1, tag, c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi;
    int cyc;
    int base;
    int dbase;
    logic [31:0] exp_order [6];

    // Reset then idle
    repeat (2) @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_outputs", {mem_we, if_ready, d_ready, err_timeout, stall}, 0);
    check("rst_data", {mem_addr, mem_wdata}, 0);
    check("rst_rdata", {if_rdata, d_rdata}, 0);
    rst = 1'b0;
    hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_req) hi++;
    end
    check("idle_no_req", hi, 0);

    // Single fetch, zero-latency memory
    mem_lat = 0;
    base = g_addr.size();
    if_addr = 32'h40;
    if_req  = 1'b1;
    exp_if.push_back(ref_read(32'h40));
    #1 check("fetch_stall_hi", stall, 1);
    wait_done(1'b0, "fetch_rdata", cyc);
    check("fetch_latency", cyc, 2);
    check("fetch_stall_ready", stall, 0);
    check("fetch_rdata_const", if_rdata, 32'h8C22_0004);
    if_req = 1'b0;
    @(negedge clk);
    check("fetch_ready_pulse", if_ready, 0);
    check("fetch_grants", g_addr.size() - base, 1);
    if (g_addr.size() > base) begin
      check("fetch_mem_addr", g_addr[base], 32'h40);
      check("fetch_mem_we", g_we[base], 0);
    end

    // Store then load, 3-cycle memory
    mem_lat = 3;
    base  = g_addr.size();
    dbase = d_ready_cnt;
    data_op(1'b1, 32'h100, 32'hDEAD_BEEF, "store_rdata_kept");
    data_op(1'b0, 32'h100, 32'h0, "load_after_store");
    d_req = 1'b0;
    @(negedge clk);
    check("sl_ready_count", d_ready_cnt - dbase, 2);
    check("sl_grants", g_addr.size() - base, 2);
    if (g_addr.size() >= base + 2) begin
      check("store_mem_we", g_we[base], 1);
      check("store_mem_addr", g_addr[base], 32'h100);
      check("store_mem_wdata", g_wdata[base], 32'hDEAD_BEEF);
      check("load_mem_we", g_we[base+1], 0);
    end

    // Contention: both requesters held, expect D,D,F,D,D,F
    mem_lat = 1;
    base = g_addr.size();
    fork
      begin
        fetch_op(32'h200, 1'b0, "cont_f0");
        fetch_op(32'h204, 1'b0, "cont_f1");
        if_req = 1'b0;
      end
      begin
        for (int k = 0; k < 4; k++) data_op(1'b0, 32'h300 + 32'(4*k), 32'h0, "cont_d");
        d_req = 1'b0;
      end
    join
    @(negedge clk);
    exp_order = '{32'h300, 32'h304, 32'h200, 32'h308, 32'h30C, 32'h204};
    check("cont_grant_count", g_addr.size() - base, 6);
    if (g_addr.size() >= base + 6)
      for (int k = 0; k < 6; k++) check($sformatf("cont_order%0d", k), g_addr[base+k], exp_order[k]);

    // Timeout with a dead memory, then ack on the last allowed edge
    check("err_before_to", err_timeout, 0);
    mem_dead = 1'b1;
    fetch_op(32'h500, 1'b1, "to_fetch_rdata0");
    if_req = 1'b0;
    @(negedge clk);
    check("to_req_len", len_log[$], 15);
    check("to_err_set", err_timeout, 1);
    mem_dead = 1'b0;
    mem_lat  = 14;
    data_op(1'b0, 32'h100, 32'h0, "ack_last_edge_rdata");
    d_req = 1'b0;
    @(negedge clk);
    check("ack_last_req_len", len_log[$], 15);
    check("to_err_sticky", err_timeout, 1);

    // Reset in the middle of a store
    mem_lat = 10;
    d_we    = 1'b1;
    d_addr  = 32'h100;
    d_wdata = 32'h1234_5678;
    d_req   = 1'b1;
    for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
    check("mid_req_up", mem_req, 1);
    dbase = d_ready_cnt;
    #2 rst = 1'b1;
    #1 check("mid_async_req", mem_req, 0);
    check("mid_err_cleared", err_timeout, 0);
    @(negedge clk);
    d_req = 1'b0;
    rst   = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_no_ready", d_ready_cnt - dbase, 0);
    check("mid_idle_req", mem_req, 0);
    mem_lat = 0;
    data_op(1'b0, 32'h100, 32'h0, "post_rst_load");
    d_req = 1'b0;
    fetch_op(32'h40, 1'b0, "post_rst_fetch");
    if_req = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
